bp_be_mem_lane_arbiter: RTL and testbench

- Shares the single D$ pipe (pipe_mem) between the two dispatch lanes of the dual-issue backend.
- Each cycle, up to two memory ops arrive from one dispatch group. Lane 1 is always older than lane 2.
- The block issues them to pipe_mem strictly in program order, one per cycle, and buffers the ops it cannot issue yet in a 2-entry in-order buffer.
- It back-pressures the detector via ready_o, and flushes on director poison.

---
 rtl/bp_be_pkg.sv | 15 +
 rtl/bp_be_mem_arb_buffer.sv | 55 +++++
 rtl/bp_be_mem_lane_arbiter.sv | 114 +++++++++++
 tb/tb_bp_be_mem_lane_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared backend types for the mem-lane arbiter.
package bp_be_pkg;

  // Dispatch packet width that the buffer entry type is built around.
  localparam int unsigned bp_be_dispatch_pkt_width_gp = 128;

  // The in-order buffer has exactly two slots, one per dispatch lane.
  localparam int unsigned bp_be_mem_arb_els_gp = 2;

  typedef struct packed {
    logic                                   lane;  // 0 = lane 1, 1 = lane 2
    logic [bp_be_dispatch_pkt_width_gp-1:0] pkt;
  } bp_be_mem_arb_entry_s;

endpackage

// File: rtl/bp_be_mem_arb_buffer.sv
// Two-entry in-order buffer: up to two enqueues per cycle, one dequeue, flush.
module bp_be_mem_arb_buffer
  import bp_be_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic [1:0]           enq_cnt_i,
  input  bp_be_mem_arb_entry_s enq0_i,
  input  bp_be_mem_arb_entry_s enq1_i,
  input  logic                 deq_i,
  output bp_be_mem_arb_entry_s head_o,
  output logic [1:0]           count_o
);

  bp_be_mem_arb_entry_s mem_q [bp_be_mem_arb_els_gp];
  logic [1:0]           count_q, count_d;
  logic                 head_q, head_d;
  logic                 wr_idx0, wr_idx1;

  // Next count/head; the write slot follows the occupied entries.
  always_comb begin
    wr_idx0 = head_q ^ count_q[0];
    wr_idx1 = ~wr_idx0;
    count_d = count_q + enq_cnt_i - {1'b0, deq_i};
    head_d  = deq_i ? ~head_q : head_q;
    if (flush_i) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Payload storage; no reset needed since count gates every read.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i) begin
      if (enq_cnt_i != 2'd0) mem_q[wr_idx0] <= enq0_i;
      if (enq_cnt_i == 2'd2) mem_q[wr_idx1] <= enq1_i;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/bp_be_mem_lane_arbiter.sv
// Shares the single D$ pipe between the two dispatch lanes, issuing in program
// order with zero-latency bypass and a 2-entry overflow buffer.
// Optional statistics counters: define BP_BE_MEM_ARB_STATS_EN.
module bp_be_mem_lane_arbiter
  import bp_be_pkg::*;
#(
  parameter int unsigned dispatch_pkt_width_p = 128,
  parameter int unsigned buf_els_p            = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            flush_i,
  input  logic                            lane1_v_i,
  input  logic [dispatch_pkt_width_p-1:0] lane1_pkt_i,
  input  logic                            lane2_v_i,
  input  logic [dispatch_pkt_width_p-1:0] lane2_pkt_i,
  output logic                            ready_o,
  output logic                            mem_v_o,
  output logic [dispatch_pkt_width_p-1:0] mem_pkt_o,
  output logic                            mem_lane_o,
  input  logic                            mem_ready_i
`ifdef BP_BE_MEM_ARB_STATS_EN
  ,
  output logic [31:0]                     dual_cnt_o,
  output logic [31:0]                     stall_cnt_o
`endif
);

  if (buf_els_p != bp_be_mem_arb_els_gp) begin : g_bad_els
    $fatal(1, "bp_be_mem_lane_arbiter: buf_els_p must be 2");
  end
  // The buffer entry type is sized by the package packet width.
  if (dispatch_pkt_width_p != bp_be_dispatch_pkt_width_gp) begin : g_bad_width
    $fatal(1, "bp_be_mem_lane_arbiter: dispatch_pkt_width_p must match bp_be_pkg");
  end

  bp_be_mem_arb_entry_s head, byp, sel, enq0, enq1;
  logic [1:0]           buf_count, enq_cnt;
  logic                 accept, in_v1, in_v2, fire, deq, buf_busy;

  // Acceptance, bypass/head selection, handshake and enqueue decision.
  always_comb begin
    buf_busy = (buf_count != 2'd0);
    ready_o  = ~reset_i & ~buf_busy;
    accept   = ready_o & ~flush_i;
    in_v1    = accept & lane1_v_i;
    in_v2    = accept & lane2_v_i;

    // Oldest incoming op: lane 1 if present, otherwise lane 2.
    byp.lane = ~in_v1;
    byp.pkt  = in_v1 ? lane1_pkt_i : lane2_pkt_i;
    sel      = buf_busy ? head : byp;

    mem_v_o    = ~reset_i & ~flush_i & (buf_busy | in_v1 | in_v2);
    mem_pkt_o  = mem_v_o ? sel.pkt  : '0;
    mem_lane_o = mem_v_o ? sel.lane : 1'b0;

    fire = mem_v_o & mem_ready_i;
    deq  = fire & buf_busy;

    enq_cnt   = 2'd0;
    enq0      = byp;
    enq1.lane = 1'b1;
    enq1.pkt  = lane2_pkt_i;
    // Enqueue only happens with an empty buffer since ready_o requires it.
    if (in_v1 && in_v2) begin
      enq_cnt = fire ? 2'd1 : 2'd2;
      if (fire) enq0 = enq1;
    end else if ((in_v1 || in_v2) && !fire) begin
      enq_cnt = 2'd1;
    end
  end

  bp_be_mem_arb_buffer u_buffer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .flush_i   (flush_i),
    .enq_cnt_i (enq_cnt),
    .enq0_i    (enq0),
    .enq1_i    (enq1),
    .deq_i     (deq),
    .head_o    (head),
    .count_o   (buf_count)
  );

`ifdef BP_BE_MEM_ARB_STATS_EN
  logic [31:0] dual_cnt_q, dual_cnt_d, stall_cnt_q, stall_cnt_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    dual_cnt_d  = dual_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (in_v1 && in_v2 && (dual_cnt_q != 32'hFFFF_FFFF)) dual_cnt_d = dual_cnt_q + 32'd1;
    if (buf_busy && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dual_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      dual_cnt_q  <= dual_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dual_cnt_o  = dual_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_bp_be_mem_lane_arbiter.sv
// Directed self-checking bench for bp_be_mem_lane_arbiter.
module tb_bp_be_mem_lane_arbiter;

  localparam int unsigned W = 128;

  logic         clk_i = 1'b0;
  logic         reset_i, flush_i, lane1_v_i, lane2_v_i, mem_ready_i;
  logic [W-1:0] lane1_pkt_i, lane2_pkt_i;
  logic         ready_o, mem_v_o, mem_lane_o;
  logic [W-1:0] mem_pkt_o;
`ifdef BP_BE_MEM_ARB_STATS_EN
  logic [31:0]  dual_cnt_o, stall_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [W-1:0] PktA = 128'hA0A0_0000_0000_0000_0000_0000_0000_000A;
  localparam logic [W-1:0] PktB = 128'hB0B0_0000_0000_0000_0000_0000_0000_000B;
  localparam logic [W-1:0] PktC = 128'hC0C0_0000_0000_0000_0000_0000_0000_000C;
  localparam logic [W-1:0] PktD = 128'hD0D0_0000_0000_0000_0000_0000_0000_000D;
  localparam logic [W-1:0] PktE = 128'hE0E0_0000_0000_0000_0000_0000_0000_000E;

  always #5 clk_i = ~clk_i;

  bp_be_mem_lane_arbiter dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .flush_i     (flush_i),
    .lane1_v_i   (lane1_v_i),
    .lane1_pkt_i (lane1_pkt_i),
    .lane2_v_i   (lane2_v_i),
    .lane2_pkt_i (lane2_pkt_i),
    .ready_o     (ready_o),
    .mem_v_o     (mem_v_o),
    .mem_pkt_o   (mem_pkt_o),
    .mem_lane_o  (mem_lane_o),
    .mem_ready_i (mem_ready_i)
`ifdef BP_BE_MEM_ARB_STATS_EN
    ,
    .dual_cnt_o  (dual_cnt_o),
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic [W-1:0] p1, input logic v2,
                       input logic [W-1:0] p2, input logic mr, input logic fl);
    lane1_v_i   = v1;
    lane1_pkt_i = p1;
    lane2_v_i   = v2;
    lane2_pkt_i = p2;
    mem_ready_i = mr;
    flush_i     = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic probe();
    @(negedge clk_i);
  endtask

  int leaks;

  initial begin
    reset_i = 1'b1;
    // Valid input during reset must be ignored.
    drive(1'b1, PktA, 1'b1, PktB, 1'b1, 1'b0);
    repeat (2) begin
      probe();
      check_eq("rst_ready", ready_o, 0);
      check_eq("rst_mem_v", mem_v_o, 0);
      check_eq("rst_pkt", mem_pkt_o, 0);
      check_eq("rst_lane", mem_lane_o, 0);
    end
    tick();
    reset_i = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    probe();
    check_eq("idle_ready", ready_o, 1);
    check_eq("idle_mem_v", mem_v_o, 0);

    // Dual group, pipe ready: A bypasses, B follows from the buffer.
    tick();
    drive(1'b1, PktA, 1'b1, PktB, 1'b1, 1'b0);
    probe();
    check_eq("t1_c0_v", mem_v_o, 1);
    check_eq("t1_c0_pkt", mem_pkt_o, PktA);
    check_eq("t1_c0_lane", mem_lane_o, 0);
    check_eq("t1_c0_ready", ready_o, 1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    probe();
    check_eq("t1_c1_ready", ready_o, 0);
    check_eq("t1_c1_v", mem_v_o, 1);
    check_eq("t1_c1_pkt", mem_pkt_o, PktB);
    check_eq("t1_c1_lane", mem_lane_o, 1);
    tick();
    probe();
    check_eq("t1_c2_ready", ready_o, 1);
    check_eq("t1_c2_v", mem_v_o, 0);

    // Dual group, pipe stalled 3 cycles: A held, then A, B.
    tick();
    drive(1'b1, PktA, 1'b1, PktB, 1'b0, 1'b0);
    probe();
    check_eq("t2_c0_pkt", mem_pkt_o, PktA);
    check_eq("t2_c0_v", mem_v_o, 1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      probe();
      check_eq("t2_stall_pkt", mem_pkt_o, PktA);
      check_eq("t2_stall_lane", mem_lane_o, 0);
      check_eq("t2_stall_v", mem_v_o, 1);
      check_eq("t2_stall_ready", ready_o, 0);
      check_eq("t2_stall_count", dut.buf_count, 2);
      tick();
    end
    mem_ready_i = 1'b1;
    probe();
    check_eq("t2_issue_a", mem_pkt_o, PktA);
    tick();
    probe();
    check_eq("t2_issue_b", mem_pkt_o, PktB);
    check_eq("t2_issue_b_lane", mem_lane_o, 1);
    check_eq("t2_issue_b_v", mem_v_o, 1);
    tick();
    probe();
    check_eq("t2_done_ready", ready_o, 1);
    check_eq("t2_done_v", mem_v_o, 0);

    // Lane 2 only: bypass with lane=1, nothing buffered.
    tick();
    drive(1'b0, '0, 1'b1, PktC, 1'b1, 1'b0);
    probe();
    check_eq("t3_v", mem_v_o, 1);
    check_eq("t3_pkt", mem_pkt_o, PktC);
    check_eq("t3_lane", mem_lane_o, 1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    probe();
    check_eq("t3_count", dut.buf_count, 0);
    check_eq("t3_ready", ready_o, 1);
    check_eq("t3_after_v", mem_v_o, 0);

    // Buffer A,B then flush: nothing is ever issued.
    tick();
    drive(1'b1, PktA, 1'b1, PktB, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    probe();
    check_eq("t4_flush_v", mem_v_o, 0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    probe();
    check_eq("t4_count", dut.buf_count, 0);
    check_eq("t4_ready", ready_o, 1);
    leaks = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_v_o) leaks++;
      tick();
      probe();
    end
    check_eq("t4_no_issue", leaks, 0);

    // Reset mid-stall with two buffered ops.
    tick();
    drive(1'b1, PktA, 1'b1, PktB, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    probe();
    check_eq("t5_count2", dut.buf_count, 2);
    tick();
    reset_i     = 1'b1;
    mem_ready_i = 1'b1;
    probe();
    check_eq("t5_rst_v", mem_v_o, 0);
    check_eq("t5_rst_ready", ready_o, 0);
    check_eq("t5_rst_pkt", mem_pkt_o, 0);
    check_eq("t5_rst_lane", mem_lane_o, 0);
    tick();
    reset_i = 1'b0;
    probe();
    check_eq("t5_post_count", dut.buf_count, 0);
    check_eq("t5_post_ready", ready_o, 1);
    check_eq("t5_post_v", mem_v_o, 0);
    tick();
    drive(1'b1, PktD, 1'b1, PktE, 1'b1, 1'b0);
    probe();
    check_eq("t5_d_pkt", mem_pkt_o, PktD);
    check_eq("t5_d_lane", mem_lane_o, 0);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    probe();
    check_eq("t5_e_pkt", mem_pkt_o, PktE);
    check_eq("t5_e_lane", mem_lane_o, 1);
    tick();
    probe();
    check_eq("t5_end_ready", ready_o, 1);

`ifdef BP_BE_MEM_ARB_STATS_EN
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    probe();
    check_eq("st_rst_dual", dual_cnt_o, 0);
    check_eq("st_rst_stall", stall_cnt_o, 0);
    for (int g = 0; g < 3; g++) begin
      tick();
      drive(1'b1, PktA, 1'b1, PktB, 1'b1, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    probe();
    check_eq("st_dual", dual_cnt_o, 3);
    check_eq("st_stall", stall_cnt_o, 3);
    tick();
    drive(1'b1, PktA, 1'b1, PktB, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    probe();
    check_eq("st_flush_dual", dual_cnt_o, 3);
    check_eq("st_flush_stall", stall_cnt_o, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
